// File: rtl/dbchecker_pkg.sv
// Shared definitions for the DMA bounds checker DBTE fetch path.
package dbchecker_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned DBTE_ENTRY_BYTES = 16;
  localparam int unsigned ENTRY_SHIFT      = $clog2(DBTE_ENTRY_BYTES);
  localparam int unsigned DBTE_DATA_W      = DBTE_ENTRY_BYTES * 8;

  typedef logic [DBTE_DATA_W-1:0] dbte_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } fetch_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the priority pointer moves past the owner when its transaction is done.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_owner_i,
  output logic [1:0] gnt_o
);

  logic prio_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (done_i) begin
      prio_q <= ~done_owner_i;
    end
  end

  // prio only breaks ties; a lone requester always wins.
  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = en_i & req_i[0] & (~req_i[1] | ~prio_q);
    gnt_o[1] = en_i & req_i[1] & (~req_i[0] | prio_q);
  end

endmodule

// File: rtl/dbte_fetch_arbiter.sv
// Shares the DBTE lookup read master between the AR and AW permission checkers,
// one single-beat entry fetch in flight at a time.
module dbte_fetch_arbiter #(
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned ENTRY_SHIFT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dbte_base,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [IDX_W-1:0]  req0_idx,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [IDX_W-1:0]  req1_idx,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_axi_dbte_araddr,
  output logic [7:0]        m_axi_dbte_arlen,
  output logic [2:0]        m_axi_dbte_arsize,
  output logic [1:0]        m_axi_dbte_arburst,
  output logic              m_axi_dbte_arvalid,
  input  logic              m_axi_dbte_arready,
  input  logic [DATA_W-1:0] m_axi_dbte_rdata,
  input  logic [1:0]        m_axi_dbte_rresp,
  input  logic              m_axi_dbte_rlast,
  input  logic              m_axi_dbte_rvalid,
  output logic              m_axi_dbte_rready,
  output logic              busy
);

  import dbchecker_pkg::*;

  fetch_state_e      state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [1:0]        gnt;
  logic              arb_en;
  logic              accept;
  logic              rsp_ready_sel;
  logic              done;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] entry_addr;

  // Acceptance is suppressed while reset is asserted so a held request is not lost.
  assign arb_en        = (state_q == StIdle) & reset;
  assign accept        = |gnt;
  assign rsp_ready_sel = owner_q ? rsp1_ready : rsp0_ready;
  assign done          = (state_q == StResp) & rsp_ready_sel;
  assign sel_idx       = gnt[1] ? req1_idx : req0_idx;
  // Index zero-extended; the sum wraps modulo 2^ADDR_W.
  assign entry_addr    = dbte_base + (ADDR_W'(sel_idx) << ENTRY_SHIFT);

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i        (clock),
    .rst_ni       (reset),
    .en_i         (arb_en),
    .req_i        ({req1_valid, req0_valid}),
    .done_i       (done),
    .done_owner_i (owner_q),
    .gnt_o        (gnt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      araddr_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q  <= gnt[1];
            araddr_q <= entry_addr;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          if (m_axi_dbte_arready) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (m_axi_dbte_rvalid) begin
            rsp_data_q <= m_axi_dbte_rdata;
            rsp_err_q  <= (m_axi_dbte_rresp != RESP_OKAY) | ~m_axi_dbte_rlast;
            state_q    <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_sel) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req0_ready         = gnt[0];
  assign req1_ready         = gnt[1];
  assign rsp0_valid         = (state_q == StResp) & ~owner_q;
  assign rsp1_valid         = (state_q == StResp) & owner_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_err            = rsp_err_q;
  assign m_axi_dbte_araddr  = araddr_q;
  assign m_axi_dbte_arlen   = 8'd0;
  assign m_axi_dbte_arsize  = 3'(ENTRY_SHIFT);
  assign m_axi_dbte_arburst = BURST_INCR;
  assign m_axi_dbte_arvalid = (state_q == StAddr);
  assign m_axi_dbte_rready  = (state_q == StData);
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_dbte_fetch_arbiter.sv
// Scoreboard bench for the DBTE fetch arbiter: grant order, address math, error flag,
// backpressure and mid-transaction reset.
module tb_dbte_fetch_arbiter;
  import dbchecker_pkg::*;

  localparam int unsigned ADDR_W = 48;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned IDX_W  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] dbte_base;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [IDX_W-1:0]  req0_idx, req1_idx;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic              busy;

  always #5 clock = ~clock;

  dbte_fetch_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .dbte_base          (dbte_base),
    .req0_valid         (req0_valid),
    .req0_ready         (req0_ready),
    .req0_idx           (req0_idx),
    .req1_valid         (req1_valid),
    .req1_ready         (req1_ready),
    .req1_idx           (req1_idx),
    .rsp0_valid         (rsp0_valid),
    .rsp0_ready         (rsp0_ready),
    .rsp1_valid         (rsp1_valid),
    .rsp1_ready         (rsp1_ready),
    .rsp_data           (rsp_data),
    .rsp_err            (rsp_err),
    .m_axi_dbte_araddr  (araddr),
    .m_axi_dbte_arlen   (arlen),
    .m_axi_dbte_arsize  (arsize),
    .m_axi_dbte_arburst (arburst),
    .m_axi_dbte_arvalid (arvalid),
    .m_axi_dbte_arready (arready),
    .m_axi_dbte_rdata   (rdata),
    .m_axi_dbte_rresp   (rresp),
    .m_axi_dbte_rlast   (rlast),
    .m_axi_dbte_rvalid  (rvalid),
    .m_axi_dbte_rready  (rready),
    .busy               (busy)
  );

  typedef struct packed {
    logic              owner;
    logic [ADDR_W-1:0] addr;
  } req_exp_t;

  typedef struct packed {
    logic        owner;
    dbte_entry_t data;
    logic        err;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  logic     model_prio;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_arvalid"}, arvalid, 1'b0);
    check_eq({tag, "_rready"}, rready, 1'b0);
    check_eq({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
    check_eq({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
    check_eq({tag, "_req_ready"}, {req1_ready, req0_ready}, 2'b00);
  endtask

  // Raise the requested valids (existing ones stay), wait for a grant and record the expectation.
  task automatic accept(input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1,
                        input bit v0, input bit v1);
    logic              win;
    logic [ADDR_W-1:0] a;
    bit                got;
    got = 1'b0;
    req0_idx = i0;
    req1_idx = i1;
    if (v0) req0_valid = 1'b1;
    if (v1) req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (req0_ready | req1_ready) got = 1'b1;
      else tick();
    end
    if (!got) begin
      check_eq("accept_timeout", 1'b0, 1'b1);
      return;
    end
    win = (req0_valid & req1_valid) ? model_prio : req1_valid;
    check_eq("grant0", req0_ready, !win);
    check_eq("grant1", req1_ready, win);
    a = {{(ADDR_W-IDX_W){1'b0}}, (win ? req1_idx : req0_idx)};
    a = dbte_base + (a << 4);
    req_q.push_back('{owner: win, addr: a});
    tick();
    if (win) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  // Called on the first ADDR cycle; plays slave and consumer for one fetch.
  task automatic serve(input dbte_entry_t d, input logic [1:0] resp, input logic last,
                       input int ar_wait, input int rsp_wait, input bit change_base);
    req_exp_t          re;
    rsp_exp_t          rs;
    logic [ADDR_W-1:0] a0;
    if (req_q.size() == 0) begin
      check_eq("req_queue_empty", 1'b0, 1'b1);
      return;
    end
    re = req_q.pop_front();
    if (change_base) dbte_base = ~dbte_base;
    check_eq("arvalid", arvalid, 1'b1);
    check_eq("araddr", araddr, re.addr);
    check_eq("arlen", arlen, 8'd0);
    check_eq("arsize", arsize, 3'd4);
    check_eq("arburst", arburst, 2'b01);
    check_eq("busy", busy, 1'b1);
    a0 = araddr;
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      check_eq("arvalid_hold", arvalid, 1'b1);
      check_eq("araddr_hold", araddr, a0);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("rready", rready, 1'b1);
    check_eq("arvalid_drop", arvalid, 1'b0);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    rlast  = last;
    rsp_q.push_back('{owner: re.owner, data: d, err: (resp != 2'b00) | !last});
    tick();
    rvalid = 1'b0;
    rdata  = ~d;
    rs = rsp_q.pop_front();
    check_eq("rsp_valid_owner", rs.owner ? rsp1_valid : rsp0_valid, 1'b1);
    check_eq("rsp_valid_other", rs.owner ? rsp0_valid : rsp1_valid, 1'b0);
    check_eq("rsp_data", rsp_data, rs.data);
    check_eq("rsp_err", rsp_err, rs.err);
    for (int i = 0; i < rsp_wait; i++) begin
      tick();
      check_eq("rsp_valid_hold", rs.owner ? rsp1_valid : rsp0_valid, 1'b1);
      check_eq("rsp_data_hold", rsp_data, rs.data);
      check_eq("req_ready_in_resp", {req1_ready, req0_ready}, 2'b00);
    end
    if (rs.owner) rsp1_ready = 1'b1;
    else rsp0_ready = 1'b1;
    #1;
    check_eq("no_accept_in_resp", {req1_ready, req0_ready}, 2'b00);
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    model_prio = ~rs.owner;
    check_eq("busy_done", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    dbte_base  = '0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_idx   = '0;
    req1_idx   = '0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    arready    = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    rlast      = 1'b0;
    rvalid     = 1'b0;
    model_prio = 1'b0;
    tick();
    tick();
    tick();
    check_quiet("reset");
    check_eq("reset_araddr", araddr, 48'h0);
    check_eq("reset_rsp_data", rsp_data, 128'h0);
    check_eq("reset_rsp_err", rsp_err, 1'b0);
    reset = 1'b1;
    tick();

    // Single fetch.
    dbte_base = 48'h0000_8000_0000;
    accept(16'd3, 16'd0, 1'b1, 1'b0);
    check_eq("single_araddr", araddr, 48'h0000_8000_0030);
    serve({16{8'hA5}}, 2'b00, 1'b1, 0, 0, 1'b0);

    // Contention: expected order 0,1,0,1 with requester 1 kept pending.
    dbte_base = 48'h0000_1000_0000;
    accept(16'd10, 16'd20, 1'b1, 1'b1);
    serve(128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 2'b00, 1'b1, 0, 0, 1'b0);
    accept(16'd11, 16'd20, 1'b1, 1'b0);
    serve(128'hdead_beef_0000_1111_2222_3333_4444_5555, 2'b00, 1'b1, 1, 0, 1'b0);
    accept(16'd11, 16'd21, 1'b0, 1'b1);
    serve(128'h1, 2'b00, 1'b1, 0, 1, 1'b0);
    accept(16'd13, 16'd21, 1'b1, 1'b0);
    serve(128'h2, 2'b00, 1'b1, 0, 0, 1'b0);

    // Error flag from a bad response and from a missing rlast.
    accept(16'd5, 16'd0, 1'b1, 1'b0);
    serve(128'h5555, 2'b10, 1'b1, 0, 0, 1'b0);
    accept(16'd6, 16'd0, 1'b1, 1'b0);
    serve(128'h6666, 2'b00, 1'b0, 0, 0, 1'b0);

    // Address backpressure plus a base change after grant.
    accept(16'd7, 16'd0, 1'b1, 1'b0);
    serve(128'h7777, 2'b00, 1'b1, 5, 0, 1'b1);

    // Response backpressure on requester 1 with requester 0 waiting.
    accept(16'd0, 16'd9, 1'b0, 1'b1);
    req0_idx   = 16'd8;
    req0_valid = 1'b1;
    serve(128'h9999_aaaa, 2'b00, 1'b1, 0, 3, 1'b0);
    accept(16'd8, 16'd0, 1'b0, 1'b0);
    serve(128'h8888, 2'b00, 1'b1, 0, 0, 1'b0);

    // Address wrap.
    dbte_base = 48'hFFFF_FFFF_FFF0;
    accept(16'd2, 16'd0, 1'b1, 1'b0);
    check_eq("wrap_araddr", araddr, 48'h0000_0000_0010);
    serve(128'hfeed, 2'b01, 1'b1, 0, 0, 1'b0);

    // Reset while waiting for read data.
    dbte_base = 48'h0000_0004_0000;
    accept(16'd4, 16'd0, 1'b1, 1'b0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("pre_reset_rready", rready, 1'b1);
    reset = 1'b0;
    tick();
    check_quiet("midreset");
    check_eq("midreset_araddr", araddr, 48'h0);
    reset = 1'b1;
    req_q.delete();
    rsp_q.delete();
    model_prio = 1'b0;
    tick();
    accept(16'd1, 16'd0, 1'b1, 1'b0);
    check_eq("post_reset_araddr", araddr, 48'h0000_0004_0010);
    serve(128'hc0ffee, 2'b00, 1'b1, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
